// File: rtl/cnn_layer_seq_if.sv
// cnn_layer_seq_if
// Bundles every signal of the multi-layer CNN sequencer except clock and reset.
//   master : the sequencer side (drives strobes, address, status)
//   slave  : the environment side (drives start/abort/pad_skip and the
//            fill_valid / dot_ready handshake halves)
// Signals:
//   start, abort, pad_skip[NUM_LAYERS]      run control
//   fill_valid / fill_ready                 fill source handshake
//   dot_ready                               dot engine read acceptance
//   ram_we, ram_re, ram_addr[ADDR_W]        shared RAM port
//   zpad_load, dot_last, bias_load          phase strobes
//   cs_layer[LAYER_W], layer_done           layer progress
//   busy, valid, err                        run status
interface cnn_layer_seq_if #(
    parameter int NUM_LAYERS = 4,
    parameter int LAYER_W    = 4,
    parameter int ADDR_W     = 9
);
    logic                  start;
    logic                  abort;
    logic [NUM_LAYERS-1:0] pad_skip;
    logic                  fill_valid;
    logic                  fill_ready;
    logic                  dot_ready;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_W-1:0]     ram_addr;
    logic                  zpad_load;
    logic                  dot_last;
    logic                  bias_load;
    logic [LAYER_W-1:0]    cs_layer;
    logic                  layer_done;
    logic                  busy;
    logic                  valid;
    logic                  err;

    modport master (
        input  start, abort, pad_skip, fill_valid, dot_ready,
        output fill_ready, ram_we, ram_re, ram_addr, zpad_load, dot_last,
               bias_load, cs_layer, layer_done, busy, valid, err
    );

    modport slave (
        output start, abort, pad_skip, fill_valid, dot_ready,
        input  fill_ready, ram_we, ram_re, ram_addr, zpad_load, dot_last,
               bias_load, cs_layer, layer_done, busy, valid, err
    );
endinterface

// File: rtl/cnn_layer_seq.sv
// cnn_layer_seq
// Multi-layer sequencer for the CNN datapath. For each of NUM_LAYERS layers it
// walks ZPAD -> FILL -> DOTP -> DRAIN -> BIAS, then signals completion in FINI.
// It owns the shared RAM address counter, writes DEPTH source words in FILL and
// reads them back in DOTP, waits PIPE_LAT cycles for the dot pipeline to settle
// and traps into ERR if the fill source stalls for TIMEOUT cycles.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    cnn_layer_seq_if.master (handshakes, RAM port, strobes, status)
module cnn_layer_seq #(
    parameter int NUM_LAYERS = 4,
    parameter int LAYER_W    = 4,
    parameter int ADDR_W     = 9,
    parameter int DEPTH      = 288,
    parameter int PIPE_LAT   = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    cnn_layer_seq_if.master  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ZPAD  = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_DOTP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_BIAS  = 3'd5;
    localparam logic [2:0] S_FINI  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int DR_W = $clog2(PIPE_LAT + 1);

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [TO_W-1:0]    LAST_TO    = TO_W'(TIMEOUT - 1);
    localparam logic [DR_W-1:0]    LAST_DR    = DR_W'(PIPE_LAT - 1);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [DR_W-1:0]    drain_q, drain_d;
    logic               err_q, err_d;

    logic                  accept;
    logic                  rdFire;
    logic [LAYER_W-1:0]    nextLayer;
    logic [NUM_LAYERS-1:0] padShift;
    logic                  nextSkip;

    // Handshake fires are suppressed by abort so no RAM traffic leaks out in
    // the abort cycle.
    assign accept    = (state_q == S_FILL) && bus.fill_valid && !bus.abort;
    assign rdFire    = (state_q == S_DOTP) && bus.dot_ready && !bus.abort;
    assign nextLayer = layer_q + 1'b1;
    // Shift rather than index so the select width never depends on LAYER_W.
    assign padShift  = bus.pad_skip >> nextLayer;
    assign nextSkip  = padShift[0];

    // Next-state logic. The timeout and drain counters default to zero so that
    // each FILL / DRAIN visit starts counting from a clean value.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        layer_d = layer_q;
        to_d    = '0;
        drain_d = '0;
        err_d   = err_q;
        if (bus.abort) begin
            state_d = S_IDLE;
            addr_d  = '0;
            layer_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        layer_d = '0;
                        addr_d  = '0;
                        state_d = bus.pad_skip[0] ? S_FILL : S_ZPAD;
                    end
                end
                S_ZPAD: state_d = S_FILL;
                S_FILL: begin
                    if (bus.fill_valid) begin
                        if (addr_q == LAST_ADDR) begin
                            addr_d  = '0;
                            state_d = S_DOTP;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end else if (to_q == LAST_TO) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                S_DOTP: begin
                    if (bus.dot_ready) begin
                        if (addr_q == LAST_ADDR) begin
                            addr_d  = '0;
                            state_d = S_DRAIN;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == LAST_DR) begin
                        state_d = S_BIAS;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                S_BIAS: begin
                    if (layer_q == LAST_LAYER) begin
                        state_d = S_FINI;
                    end else begin
                        layer_d = nextLayer;
                        state_d = nextSkip ? S_FILL : S_ZPAD;
                    end
                end
                S_FINI:  state_d = S_IDLE;
                default: state_d = S_ERR;
            endcase
        end
    end

    // State and counter registers; reset returns everything to an idle, quiet
    // sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            layer_q <= '0;
            to_q    <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            layer_q <= layer_d;
            to_q    <= to_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    // Output decode; every strobe is masked by abort.
    always_comb begin
        bus.fill_ready = (state_q == S_FILL) && !bus.abort;
        bus.ram_we     = accept;
        bus.ram_re     = rdFire;
        bus.ram_addr   = addr_q;
        bus.zpad_load  = (state_q == S_ZPAD) && !bus.abort;
        bus.dot_last   = rdFire && (addr_q == LAST_ADDR);
        bus.bias_load  = (state_q == S_BIAS) && !bus.abort;
        bus.layer_done = (state_q == S_BIAS) && !bus.abort && (layer_q != LAST_LAYER);
        bus.cs_layer   = layer_q;
        bus.busy       = (state_q != S_IDLE);
        bus.valid      = (state_q == S_FINI) && !bus.abort;
        bus.err        = err_q;
    end
endmodule

// File: tb/tb_cnn_layer_seq.sv
// tb_cnn_layer_seq
// Self-checking bench for cnn_layer_seq with NUM_LAYERS=2, DEPTH=4, PIPE_LAT=2,
// TIMEOUT=8. Expected behaviour comes from a transaction-level view: word
// counts, addresses derived from the running write/read index, latencies
// derived from the phase lengths.
module tb_cnn_layer_seq;
    localparam int NL  = 2;
    localparam int LW  = 2;
    localparam int AW  = 4;
    localparam int DEP = 4;
    localparam int PL  = 2;
    localparam int TO  = 8;

    logic clk;
    logic rst_n;

    cnn_layer_seq_if #(.NUM_LAYERS(NL), .LAYER_W(LW), .ADDR_W(AW)) bus ();

    cnn_layer_seq #(
        .NUM_LAYERS(NL), .LAYER_W(LW), .ADDR_W(AW),
        .DEPTH(DEP), .PIPE_LAT(PL), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] padSkip;
        int         expValidCyc;
        int         expFirstBias;
        int         expZpad;
    } vec_t;

    vec_t vecs[4];

    int passCount;
    int checkCount;
    int cyc;
    int weCnt, reCnt, zpadCnt, biasCnt, doneCnt, validCnt, lastCnt;
    int lastReadCyc, validCyc, firstBiasCyc;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic fv, input logic dr);
        bus.start      = s;
        bus.abort      = a;
        bus.fill_valid = fv;
        bus.dot_ready  = dr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic resetCounters();
        weCnt = 0; reCnt = 0; zpadCnt = 0; biasCnt = 0; doneCnt = 0;
        validCnt = 0; lastCnt = 0; lastReadCyc = -100; validCyc = -1; firstBiasCyc = -1;
    endtask

    function automatic int zerosIn(input logic [1:0] p);
        return (p[0] ? 0 : 1) + (p[1] ? 0 : 1);
    endfunction

    // Per-cycle monitor: each RAM transfer is checked against the index it
    // should carry in the layer stream.
    task automatic sampleCycle();
        if (int'(bus.ram_addr) > DEP - 1) checkOutput("addr range", int'(bus.ram_addr), DEP - 1);
        if (bus.fill_ready && bus.fill_valid) checkOutput("accept gives we", int'(bus.ram_we), 1);
        if (bus.fill_ready && !bus.fill_valid) checkOutput("fill gap addr hold", int'(bus.ram_addr), weCnt % DEP);
        if (bus.ram_we) begin
            checkOutput("we needs fill_valid", int'(bus.fill_valid), 1);
            checkOutput("we addr", int'(bus.ram_addr), weCnt % DEP);
            checkOutput("we layer", int'(bus.cs_layer), weCnt / DEP);
            weCnt++;
        end
        if (bus.ram_re) begin
            checkOutput("re needs dot_ready", int'(bus.dot_ready), 1);
            checkOutput("re addr", int'(bus.ram_addr), reCnt % DEP);
            checkOutput("re layer", int'(bus.cs_layer), reCnt / DEP);
            checkOutput("dot_last", int'(bus.dot_last), (reCnt % DEP == DEP - 1) ? 1 : 0);
            if (bus.dot_last) begin lastReadCyc = cyc; lastCnt++; end
            reCnt++;
        end else if (bus.dot_last) begin
            checkOutput("dot_last without read", int'(bus.dot_last), 0);
        end
        if (bus.zpad_load) zpadCnt++;
        if (bus.layer_done) doneCnt++;
        if (bus.bias_load) begin
            checkOutput("drain latency", cyc - lastReadCyc, PL + 1);
            checkOutput("layer_done with bias", int'(bus.layer_done), (biasCnt != NL - 1) ? 1 : 0);
            if (firstBiasCyc < 0) firstBiasCyc = cyc;
            biasCnt++;
        end
        if (bus.valid) begin
            validCnt++;
            validCyc = cyc;
            checkOutput("bias count at valid", biasCnt, NL);
            checkOutput("writes at valid", weCnt, NL * DEP);
            checkOutput("reads at valid", reCnt, NL * DEP);
        end
    endtask

    task automatic runFixed(input vec_t v);
        resetCounters();
        bus.pad_skip = v.padSkip;
        cyc = 0;
        applyStimulus(1, 0, 1, 1);
        checkOutput("idle busy", int'(bus.busy), 0);
        sampleCycle();
        while (validCyc < 0 && cyc < 60) begin
            tick();
            applyStimulus(0, 0, 1, 1);
            sampleCycle();
        end
        checkOutput("valid cycle", validCyc, v.expValidCyc);
        checkOutput("first bias cycle", firstBiasCyc, v.expFirstBias);
        checkOutput("zpad count", zpadCnt, v.expZpad);
        checkOutput("layer_done count", doneCnt, NL - 1);
        checkOutput("dot_last count", lastCnt, NL);
        tick();
        applyStimulus(0, 0, 1, 1);
        checkOutput("busy after fini", int'(bus.busy), 0);
        checkOutput("valid one cycle", int'(bus.valid), 0);
    endtask

    task automatic runRandom();
        logic [1:0] p;
        int zeros;
        logic fv;
        resetCounters();
        p = 2'($urandom_range(0, 3));
        bus.pad_skip = p;
        zeros = 0;
        cyc = 0;
        applyStimulus(1, 0, 0, 0);
        sampleCycle();
        while (validCyc < 0 && cyc < 400) begin
            tick();
            fv = (zeros >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            if (fv) zeros = 0; else zeros++;
            applyStimulus(1'($urandom_range(0, 1)), 0, fv, ($urandom_range(0, 9) < 7));
            sampleCycle();
        end
        checkOutput("rand valid seen", validCnt, 1);
        checkOutput("rand zpad count", zpadCnt, zerosIn(p));
        checkOutput("rand writes", weCnt, NL * DEP);
        checkOutput("rand reads", reCnt, NL * DEP);
        checkOutput("rand layer_done", doneCnt, NL - 1);
        checkOutput("rand err", int'(bus.err), 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("rand busy after", int'(bus.busy), 0);
    endtask

    initial begin
        vecs[0] = '{padSkip: 2'b00, expValidCyc: 25, expFirstBias: 12, expZpad: 2};
        vecs[1] = '{padSkip: 2'b10, expValidCyc: 24, expFirstBias: 12, expZpad: 1};
        vecs[2] = '{padSkip: 2'b01, expValidCyc: 24, expFirstBias: 11, expZpad: 1};
        vecs[3] = '{padSkip: 2'b11, expValidCyc: 23, expFirstBias: 11, expZpad: 0};

        passCount = 0;
        checkCount = 0;
        cyc = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        bus.pad_skip = '0;
        applyStimulus(0, 0, 0, 0);

        // Reset state.
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset addr", int'(bus.ram_addr), 0);
        checkOutput("reset layer", int'(bus.cs_layer), 0);
        checkOutput("reset err", int'(bus.err), 0);
        checkOutput("reset fill_ready", int'(bus.fill_ready), 0);
        checkOutput("reset valid", int'(bus.valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed runs with full-rate handshakes and every pad_skip pattern.
        for (int i = 0; i < 4; i++) runFixed(vecs[i]);

        // Gapped fill and a three-cycle dot stall.
        $display("[TB] gapped fill / dot stall");
        resetCounters();
        bus.pad_skip = 2'b11;
        cyc = 0;
        applyStimulus(1, 0, 0, 1);
        sampleCycle();
        while (validCyc < 0 && cyc < 80) begin
            tick();
            applyStimulus(0, 0, 1'(cyc % 2), !(cyc >= 9 && cyc <= 11));
            sampleCycle();
            if (cyc >= 9 && cyc <= 11) begin
                checkOutput("stall addr hold", int'(bus.ram_addr), 1);
                checkOutput("stall no read", int'(bus.ram_re), 0);
            end
        end
        checkOutput("gapped valid", validCnt, 1);
        checkOutput("gapped dot_last", lastCnt, NL);
        tick();
        applyStimulus(0, 0, 0, 0);

        // Fill timeout into ERR; start ignored; abort recovers.
        $display("[TB] fill timeout");
        bus.pad_skip = 2'b01;
        cyc = 0;
        applyStimulus(1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("pre-timeout err", int'(bus.err), 0);
        checkOutput("pre-timeout fill_ready", int'(bus.fill_ready), 1);
        tick();
        applyStimulus(1, 0, 0, 0);
        checkOutput("timeout err", int'(bus.err), 1);
        checkOutput("timeout busy", int'(bus.busy), 1);
        checkOutput("err fill_ready", int'(bus.fill_ready), 0);
        tick();
        applyStimulus(0, 0, 1, 1);
        checkOutput("err ignores start", int'(bus.err), 1);
        checkOutput("err no zpad", int'(bus.zpad_load), 0);
        checkOutput("err no we", int'(bus.ram_we), 0);
        tick();
        applyStimulus(0, 1, 1, 1);
        checkOutput("abort cycle we", int'(bus.ram_we), 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("abort busy", int'(bus.busy), 0);
        checkOutput("abort err", int'(bus.err), 0);

        // Abort in DRAIN of layer 0, then a normal full run.
        $display("[TB] abort in drain");
        resetCounters();
        bus.pad_skip = 2'b00;
        cyc = 0;
        applyStimulus(1, 0, 1, 1);
        while (cyc < 10) begin
            tick();
            applyStimulus(0, cyc == 10, 1, 1);
            sampleCycle();
        end
        checkOutput("drain abort bias", int'(bus.bias_load), 0);
        checkOutput("drain abort reads done", reCnt, DEP);
        tick();
        applyStimulus(0, 0, 1, 1);
        checkOutput("post abort busy", int'(bus.busy), 0);
        checkOutput("post abort layer", int'(bus.cs_layer), 0);
        checkOutput("post abort addr", int'(bus.ram_addr), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            applyStimulus(0, 0, 1, 1);
            sampleCycle();
        end
        checkOutput("post abort no bias", biasCnt, 0);
        checkOutput("post abort no valid", validCnt, 0);
        runFixed(vecs[0]);

        // Asynchronous reset in the middle of DOTP.
        $display("[TB] async reset mid-dotp");
        bus.pad_skip = 2'b00;
        cyc = 0;
        applyStimulus(1, 0, 1, 1);
        while (cyc < 7) begin
            tick();
            applyStimulus(0, 0, 1, 1);
        end
        checkOutput("dotp before reset", int'(bus.ram_re), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst busy", int'(bus.busy), 0);
        checkOutput("async rst re", int'(bus.ram_re), 0);
        checkOutput("async rst addr", int'(bus.ram_addr), 0);
        checkOutput("async rst layer", int'(bus.cs_layer), 0);
        @(negedge clk);
        rst_n = 1'b1;
        resetCounters();
        for (int i = 0; i < 40; i++) begin
            tick();
            applyStimulus(0, 0, 1, 1);
            sampleCycle();
        end
        checkOutput("no valid after reset", validCnt, 0);
        checkOutput("idle after reset", int'(bus.busy), 0);

        // Randomised runs against the transaction-level expectations.
        $display("[TB] random runs");
        for (int r = 0; r < 6; r++) runRandom();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
